// File: rtl/agc_timing_pkg.sv
// Shared timing definitions for the AGC timepulse sequencer: state encoding,
// timepulse count, named T01..T12 bit positions and the one-hot rotate helper.
package agc_timing_pkg;

    localparam int NUM_TP = 12;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STEP = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_RUN  = RUN,
        ST_STEP = STEP,
        ST_HALT = HALT
    } seq_state_t;

    localparam int T01 = 0;
    localparam int T02 = 1;
    localparam int T03 = 2;
    localparam int T04 = 3;
    localparam int T05 = 4;
    localparam int T06 = 5;
    localparam int T07 = 6;
    localparam int T08 = 7;
    localparam int T09 = 8;
    localparam int T10 = 9;
    localparam int T11 = 10;
    localparam int T12 = 11;

    function automatic logic [NUM_TP-1:0] tp_rotl(input logic [NUM_TP-1:0] v);
        return {v[NUM_TP-2:0], v[NUM_TP-1]};
    endfunction

endpackage

// File: rtl/agc_tp_sequencer_tp_ring.sv
// tp_ring: sub-cycle counter plus one-hot timepulse rotator. clr forces the ring
// to all-zero; an enabled ring with no active pulse starts at T01, sub-cycle 0.
module tp_ring
    import agc_timing_pkg::*;
#(
    parameter int SUB_PER_TP = 4,
    parameter int SUB_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    output logic [NUM_TP-1:0] tp,
    output logic [SUB_W-1:0]  sub_ctr,
    output logic              mct_end
);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_PER_TP - 1);

    logic [NUM_TP-1:0] tp_n;
    logic [SUB_W-1:0]  sub_n;
    logic              end_n;

    always_comb begin
        tp_n  = tp;
        sub_n = sub_ctr;
        if (clr) begin
            tp_n  = '0;
            sub_n = '0;
        end else if (en) begin
            if (tp == '0) begin
                tp_n      = '0;
                tp_n[T01] = 1'b1;
                sub_n     = '0;
            end else if (sub_ctr == SUB_LAST) begin
                tp_n  = tp_rotl(tp);
                sub_n = '0;
            end else begin
                sub_n = sub_ctr + 1'b1;
            end
        end
        // mct_end is registered alongside tp so it lines up with the last sub-cycle of T12
        end_n = tp_n[T12] && (sub_n == SUB_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tp      <= '0;
            sub_ctr <= '0;
            mct_end <= 1'b0;
        end else begin
            tp      <= tp_n;
            sub_ctr <= sub_n;
            mct_end <= end_n;
        end
    end

endmodule

// File: rtl/agc_tp_sequencer.sv
// Timepulse sequencer top: run/stop/step FSM, pending-stop flag and memory-cycle
// counter. The counter exists only when TPG_CYCLE_COUNT_EN is defined.
module agc_tp_sequencer
    import agc_timing_pkg::*;
#(
    parameter int SUB_PER_TP = 4,
    parameter int CNT_W      = 16,
    localparam int SUB_W     = $clog2(SUB_PER_TP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              stop_req,
    input  logic              step_req,
    output logic [NUM_TP-1:0] tp,
    output logic [SUB_W-1:0]  sub_ctr,
    output logic              mct_end,
    output logic              halted,
    output logic [CNT_W-1:0]  mct_count
);

    seq_state_t state, state_n;
    logic       stop_pend;
    logic       running, running_n, ring_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (run) state_n = ST_RUN;
            end
            ST_RUN: begin
                // a stop arriving in the very last clk still halts at this boundary
                if (mct_end && (stop_pend || stop_req)) state_n = ST_HALT;
            end
            ST_STEP: begin
                if (mct_end) state_n = ST_HALT;
            end
            ST_HALT: begin
                if (run)           state_n = ST_RUN;
                else if (step_req) state_n = ST_STEP;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign running   = (state == ST_RUN) || (state == ST_STEP);
    assign running_n = (state_n == ST_RUN) || (state_n == ST_STEP);
    // ring starts one clk after entering RUN/STEP and blanks on the edge that leaves
    assign ring_clr  = !(running && running_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            stop_pend <= 1'b0;
            halted    <= 1'b0;
        end else begin
            halted <= (state_n == ST_HALT);
            if (state_n == ST_HALT)
                stop_pend <= 1'b0;
            else if (state == ST_RUN && stop_req)
                stop_pend <= 1'b1;
        end
    end

    tp_ring #(
        .SUB_PER_TP (SUB_PER_TP),
        .SUB_W      (SUB_W)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .en      (running),
        .clr     (ring_clr),
        .tp      (tp),
        .sub_ctr (sub_ctr),
        .mct_end (mct_end)
    );

`ifdef TPG_CYCLE_COUNT_EN
    logic [CNT_W-1:0] mct_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mct_count_q <= '0;
        end else if (mct_end) begin
            mct_count_q <= mct_count_q + 1'b1;
        end
    end

    assign mct_count = mct_count_q;
`else
    assign mct_count = '0;
`endif

endmodule
